// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch/store block.
package instr_fetch_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2
   } state_t;

   // Jump with offset code 11: parks the core in place.
   localparam logic [7:0] HALT_OPCODE = 8'hFF;

   localparam logic [1:0] OP_ADD   = 2'b00;
   localparam logic [1:0] OP_LOAD  = 2'b01;
   localparam logic [1:0] OP_STORE = 2'b10;
   localparam logic [1:0] OP_JUMP  = 2'b11;

endpackage

// File: rtl/instr_fetch_store_ram.sv
// Instruction RAM: DEPTH x 8, one synchronous write port, one registered read port.
module instr_ram #(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned IDX_W = 8
) (
   input  logic             CLK,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_addr,
   input  logic [7:0]       wr_data,
   input  logic [IDX_W-1:0] rd_addr,
   output logic [7:0]       rd_data
);

   logic [7:0] mem [DEPTH];

   always_ff @(posedge CLK) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/instr_fetch_store.sv
// Program store and fetch stage: byte-stream loader plus registered fetch with HALT fill.
// Optional macro LOAD_CHECKSUM_EN adds the load_checksum output.
module instr_fetch_store
   import instr_fetch_pkg::state_t;
   import instr_fetch_pkg::IDLE;
   import instr_fetch_pkg::LOAD;
   import instr_fetch_pkg::RUN;
#(
   parameter int unsigned DEPTH       = 256,
   parameter int unsigned ADDR_W      = 8,
   parameter logic [7:0]  HALT_OPCODE = instr_fetch_pkg::HALT_OPCODE
) (
   input  logic              CLK,
   input  logic              reset,
   input  logic              prog_mode,
   input  logic              prog_valid,
   input  logic [7:0]        prog_data,
   output logic              prog_ready,
   output logic              prog_overflow,
`ifdef LOAD_CHECKSUM_EN
   output logic [7:0]        load_checksum,
`endif
   output logic [ADDR_W:0]   program_len,
   input  logic [ADDR_W-1:0] readingAddress,
   output logic [7:0]        instruction,
   output logic              instr_valid
);

   localparam int unsigned PTR_W = ADDR_W + 1;
   localparam int unsigned IDX_W = $clog2(DEPTH);

   state_t             state;
   logic [PTR_W-1:0]   wr_ptr;
   logic               hit_q;
   logic [7:0]         ram_rdata;
   logic               accept;
   logic               full_offer;
   logic               enter_load;
   logic               fetch_run;
   logic               fetch_hit;

   assign prog_ready = (state == LOAD) && prog_mode && (wr_ptr < PTR_W'(DEPTH));
   assign accept     = prog_ready && prog_valid;
   assign full_offer = (state == LOAD) && prog_mode && prog_valid && (wr_ptr == PTR_W'(DEPTH));
   assign enter_load = (state != LOAD) && prog_mode;
   // Fetch only when RUN continues past this edge, so leaving RUN shows HALT immediately.
   assign fetch_run  = (state == RUN) && !prog_mode;
   assign fetch_hit  = fetch_run && ({1'b0, readingAddress} < program_len);

   assign instruction = hit_q ? ram_rdata : HALT_OPCODE;

   always_ff @(posedge CLK) begin
      if (reset) begin
         state         <= IDLE;
         wr_ptr        <= '0;
         program_len   <= '0;
         prog_overflow <= 1'b0;
         hit_q         <= 1'b0;
         instr_valid   <= 1'b0;
      end else begin
         hit_q       <= fetch_hit;
         instr_valid <= fetch_run;
         case (state)
            IDLE:    state <= prog_mode ? LOAD : RUN;
            LOAD: begin
               if (!prog_mode) begin
                  state       <= RUN;
                  program_len <= wr_ptr;
               end
            end
            RUN:     if (prog_mode) state <= LOAD;
            default: state <= IDLE;
         endcase
         if (enter_load) begin
            wr_ptr        <= '0;
            prog_overflow <= 1'b0;
         end else begin
            if (accept)     wr_ptr        <= wr_ptr + PTR_W'(1);
            if (full_offer) prog_overflow <= 1'b1;
         end
      end
   end

`ifdef LOAD_CHECKSUM_EN
   always_ff @(posedge CLK) begin
      if (reset)           load_checksum <= 8'h00;
      else if (enter_load) load_checksum <= 8'h00;
      else if (accept)     load_checksum <= load_checksum ^ prog_data;
   end
`endif

   instr_ram #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_ram (
      .CLK     (CLK),
      .wr_en   (accept),
      .wr_addr (wr_ptr[IDX_W-1:0]),
      .wr_data (prog_data),
      .rd_addr (readingAddress[IDX_W-1:0]),
      .rd_data (ram_rdata)
   );

endmodule

// File: tb/tb_instr_fetch_store.sv
// Scoreboard bench for instr_fetch_store: a full-size instance and a DEPTH=4 instance.
module tb_instr_fetch_store;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic       a_reset, a_mode, a_valid, a_ready, a_ovf, a_iv;
   logic [7:0] a_data, a_addr, a_instr;
   logic [8:0] a_len;
   logic       b_reset, b_mode, b_valid, b_ready, b_ovf, b_iv;
   logic [7:0] b_data, b_addr, b_instr;
   logic [8:0] b_len;
`ifdef LOAD_CHECKSUM_EN
   logic [7:0] a_cks, b_cks;
`endif

   instr_fetch_store #(.DEPTH(256), .ADDR_W(8)) dut (
      .CLK(CLK), .reset(a_reset), .prog_mode(a_mode), .prog_valid(a_valid),
      .prog_data(a_data), .prog_ready(a_ready), .prog_overflow(a_ovf),
`ifdef LOAD_CHECKSUM_EN
      .load_checksum(a_cks),
`endif
      .program_len(a_len), .readingAddress(a_addr), .instruction(a_instr),
      .instr_valid(a_iv)
   );

   instr_fetch_store #(.DEPTH(4), .ADDR_W(8)) dut4 (
      .CLK(CLK), .reset(b_reset), .prog_mode(b_mode), .prog_valid(b_valid),
      .prog_data(b_data), .prog_ready(b_ready), .prog_overflow(b_ovf),
`ifdef LOAD_CHECKSUM_EN
      .load_checksum(b_cks),
`endif
      .program_len(b_len), .readingAddress(b_addr), .instruction(b_instr),
      .instr_valid(b_iv)
   );

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [7:0] addr;
      logic [7:0] exp;
   } fexp_t;

   fexp_t req_q[$];
   fexp_t pend_q[$];

   // Requests issued before this edge are the ones the DUT captures on it.
   always @(posedge CLK) begin
      while (req_q.size() > 0) pend_q.push_back(req_q.pop_front());
   end

   always @(negedge CLK) begin
      if (pend_q.size() > 0) begin
         fexp_t e;
         e = pend_q.pop_front();
         total++;
         if (a_iv !== 1'b1 || a_instr !== e.exp) begin
            bad++;
            $display("FAIL fetch@%02h: instr=%02h valid=%b, want instr=%02h valid=1",
                     e.addr, a_instr, a_iv, e.exp);
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, want %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic send_a(input logic [7:0] b);
      a_valid = 1'b1;
      a_data  = b;
      step();
      a_valid = 1'b0;
   endtask

   task automatic fetch(input logic [7:0] addr, input logic [7:0] exp);
      a_addr = addr;
      req_q.push_back({addr, exp});
      step();
   endtask

   initial begin
      a_reset = 1'b1; a_mode = 1'b0; a_valid = 1'b0; a_data = 8'h00; a_addr = 8'h00;
      b_reset = 1'b1; b_mode = 1'b1; b_valid = 1'b0; b_data = 8'h00; b_addr = 8'h00;
      step(); step();

      // Reset state
      chk("rst instr", 32'(a_instr), 32'hFF);
      chk("rst instr_valid", 32'(a_iv), 32'd0);
      chk("rst prog_ready", 32'(a_ready), 32'd0);
      chk("rst overflow", 32'(a_ovf), 32'd0);
      chk("rst program_len", 32'(a_len), 32'd0);

      // 1: run with nothing loaded
      a_reset = 1'b0;
      step();
      chk("t1 valid cycle1", 32'(a_iv), 32'd0);
      step();
      chk("t1 valid cycle2", 32'(a_iv), 32'd1);
      chk("t1 instr", 32'(a_instr), 32'hFF);
      fetch(8'h00, 8'hFF);

      // 2: load three bytes and fetch them back
      a_mode = 1'b1;
      step();
      chk("t2 ready in load", 32'(a_ready), 32'd1);
      chk("t2 valid in load", 32'(a_iv), 32'd0);
      chk("t2 instr in load", 32'(a_instr), 32'hFF);
      send_a(8'h01); send_a(8'h46); send_a(8'hFD);
      a_mode = 1'b0;
      step();
      chk("t2 program_len", 32'(a_len), 32'd3);
      fetch(8'h00, 8'h01);
      fetch(8'h01, 8'h46);
      fetch(8'h02, 8'hFD);
      fetch(8'h03, 8'hFF);
      fetch(8'hFF, 8'hFF);

      // 4: mode falls together with prog_valid on byte 2
      a_mode = 1'b1;
      step();
      send_a(8'h11);
      a_valid = 1'b1; a_data = 8'h22; a_mode = 1'b0;
      step();
      a_valid = 1'b0;
      chk("t4 program_len", 32'(a_len), 32'd1);
      fetch(8'h00, 8'h11);
      fetch(8'h01, 8'hFF);

`ifdef LOAD_CHECKSUM_EN
      // 6: checksum of a load, then of an empty load
      a_mode = 1'b1;
      step();
      chk("t6 cks cleared", 32'(a_cks), 32'h00);
      send_a(8'h0F); send_a(8'hF0); send_a(8'h33);
      a_mode = 1'b0;
      step();
      chk("t6 checksum", 32'(a_cks), 32'hCC);
      a_mode = 1'b1;
      step();
      a_mode = 1'b0;
      step();
      chk("t6 empty checksum", 32'(a_cks), 32'h00);
      chk("t6 empty len", 32'(a_len), 32'd0);
      fetch(8'h00, 8'hFF);
`endif

      // 5: reset in the middle of a load
      a_mode = 1'b1;
      step();
      send_a(8'hAA); send_a(8'hBB);
      a_reset = 1'b1; a_mode = 1'b0;
      step();
      chk("t5 program_len", 32'(a_len), 32'd0);
      chk("t5 prog_ready", 32'(a_ready), 32'd0);
      chk("t5 overflow", 32'(a_ovf), 32'd0);
      a_reset = 1'b0;
      step();
      fetch(8'h00, 8'hFF);
      fetch(8'h01, 8'hFF);
      fetch(8'h02, 8'hFF);

      // 3: DEPTH=4 store offered six bytes
      b_reset = 1'b0;
      step();
      chk("t3 ready at start", 32'(b_ready), 32'd1);
      for (int i = 0; i < 6; i++) begin
         b_valid = 1'b1;
         b_data  = 8'(i + 1);
         chk($sformatf("t3 ready byte%0d", i), 32'(b_ready), (i < 4) ? 32'd1 : 32'd0);
         step();
      end
      b_valid = 1'b0;
      chk("t3 ready full", 32'(b_ready), 32'd0);
      chk("t3 overflow", 32'(b_ovf), 32'd1);
`ifdef LOAD_CHECKSUM_EN
      chk("t3 checksum", 32'(b_cks), 32'h04);
`endif
      b_mode = 1'b0;
      step();
      chk("t3 program_len", 32'(b_len), 32'd4);
      chk("t3 overflow held", 32'(b_ovf), 32'd1);
      b_addr = 8'h03;
      step();
      chk("t3 last byte", 32'(b_instr), 32'h04);
      chk("t3 valid", 32'(b_iv), 32'd1);
      b_addr = 8'h04;
      step();
      chk("t3 beyond len", 32'(b_instr), 32'hFF);

      step(); step();
      chk("scoreboard drained", 32'(req_q.size() + pend_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
